// File: rtl/esp_resp_detect.sv
// esp_resp_detect: watches the ESP32 UART byte stream after a command has been
// sent and reports whether the module answered "OK\r\n", "ERROR\r\n", or
// nothing at all within TIMEOUT_CYCLES clocks.
//
// Handshakes (both directions use strict valid/ready semantics):
//   A byte moves on rx_data only on a rising edge where rx_valid && rx_ready.
//   A result moves on resp_code only on a rising edge where resp_valid && resp_ready.
//   The producer may raise valid at any time and must hold data stable until
//   the transfer edge. The consumer may change ready freely. rx_ready and
//   resp_valid depend only on state, never combinationally on the other side.
//
// Lines are matched incrementally: pos counts bytes in the current line
// (saturating at 7). ok_hit and err_hit stay set only while every byte seen so
// far agrees with "OK\r" and "ERROR\r". A 0x0A byte closes the line. The line
// is a match only if the matching flag is still set and pos equals that
// pattern's exact length. Any other line is dropped. This drops echoed
// commands, blank lines and status chatter.
module esp_resp_detect #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic       arm,
    output logic       resp_valid,
    output logic [1:0] resp_code,
    input  logic       resp_ready,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  CH_LF     = 8'h0A;
    localparam logic [7:0]  CH_CR     = 8'h0D;
    localparam logic [1:0]  CODE_NONE = 2'b00;
    localparam logic [1:0]  CODE_OK   = 2'b01;
    localparam logic [1:0]  CODE_ERR  = 2'b10;
    localparam logic [1:0]  CODE_TMO  = 2'b11;

    // Expected byte of "OK\r" at a given line position.
    function automatic logic [7:0] ok_char(input logic [2:0] p);
        logic [7:0] c;
        case (p)
            3'd0:    c = 8'h4F; // 'O'
            3'd1:    c = 8'h4B; // 'K'
            default: c = CH_CR;
        endcase
        return c;
    endfunction

    // Expected byte of "ERROR\r" at a given line position.
    function automatic logic [7:0] err_char(input logic [2:0] p);
        logic [7:0] c;
        case (p)
            3'd0:    c = 8'h45; // 'E'
            3'd1:    c = 8'h52; // 'R'
            3'd2:    c = 8'h52; // 'R'
            3'd3:    c = 8'h4F; // 'O'
            3'd4:    c = 8'h52; // 'R'
            default: c = CH_CR;
        endcase
        return c;
    endfunction

    state_t      r_state;
    logic [31:0] r_timer;
    logic [2:0]  r_pos;
    logic        r_ok_hit;
    logic        r_err_hit;
    logic [1:0]  r_code;

    state_t      w_state_nxt;
    logic [31:0] w_timer_nxt;
    logic [2:0]  w_pos_nxt;
    logic        w_ok_nxt;
    logic        w_err_nxt;
    logic [1:0]  w_code_nxt;

    logic        w_accept;
    logic        w_is_lf;
    logic        w_ok_match;
    logic        w_err_match;
    logic        w_timeout;
    logic [2:0]  w_scan_pos;
    logic        w_scan_ok;
    logic        w_scan_err;

    // Handshake and match qualifiers derived from the registered scan state.
    always_comb begin
        rx_ready    = (r_state != S_DONE);
        w_accept    = rx_valid && rx_ready;
        w_is_lf     = (rx_data == CH_LF);
        w_ok_match  = r_ok_hit && (r_pos == 3'd3);
        w_err_match = r_err_hit && (r_pos == 3'd6);
        w_timeout   = (r_timer == TMO_LAST);
    end

    // Line scanner: update the match flags and the position for a non-LF byte.
    always_comb begin
        w_scan_ok  = r_ok_hit;
        w_scan_err = r_err_hit;
        if (r_pos >= 3'd6) begin
            w_scan_ok  = 1'b0;
            w_scan_err = 1'b0;
        end else begin
            if ((r_pos < 3'd5) && ((r_pos >= 3'd3) || (rx_data != ok_char(r_pos)))) begin
                w_scan_ok = 1'b0;
            end
            if (rx_data != err_char(r_pos)) begin
                w_scan_err = 1'b0;
            end
        end
        w_scan_pos = (r_pos == 3'd7) ? r_pos : (r_pos + 3'd1);
    end

    // FSM next-state and datapath next values; a line match has priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pos_nxt   = r_pos;
        w_ok_nxt    = r_ok_hit;
        w_err_nxt   = r_err_hit;
        w_code_nxt  = r_code;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = 32'd0;
                    w_pos_nxt   = 3'd0;
                    w_ok_nxt    = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + 32'd1;
                if (w_accept && w_is_lf && w_ok_match) begin
                    w_state_nxt = S_DONE;
                    w_code_nxt  = CODE_OK;
                end else if (w_accept && w_is_lf && w_err_match) begin
                    w_state_nxt = S_DONE;
                    w_code_nxt  = CODE_ERR;
                end else begin
                    if (w_accept && w_is_lf) begin
                        w_pos_nxt = 3'd0;
                        w_ok_nxt  = 1'b1;
                        w_err_nxt = 1'b1;
                    end else if (w_accept) begin
                        w_pos_nxt = w_scan_pos;
                        w_ok_nxt  = w_scan_ok;
                        w_err_nxt = w_scan_err;
                    end
                    if (w_timeout) begin
                        w_state_nxt = S_DONE;
                        w_code_nxt  = CODE_TMO;
                    end
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = CODE_NONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_code_nxt  = CODE_NONE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timer, line scan state and result code registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= 32'd0;
            r_pos     <= 3'd0;
            r_ok_hit  <= 1'b1;
            r_err_hit <= 1'b1;
            r_code    <= CODE_NONE;
        end else begin
            r_timer   <= w_timer_nxt;
            r_pos     <= w_pos_nxt;
            r_ok_hit  <= w_ok_nxt;
            r_err_hit <= w_err_nxt;
            r_code    <= w_code_nxt;
        end
    end

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        resp_valid  = (r_state == S_DONE);
        busy        = (r_state != S_IDLE);
        resp_code   = r_code;
        o_dbg_state = r_state;
    end

endmodule
